fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of one sync_fifo instance between NUM_REQ requesters, e.g. several DSA command sources feeding one command queue.
- Each requester pushes multi-beat packets over a valid/ready handshake.
- Once a packet starts, the arbiter locks onto that requester until its last beat, so beats from different packets never interleave in the FIFO.
- Each beat is tagged with the source ID and a last flag, so the FIFO consumer can demultiplex packets.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: lock-FSM encoding and
// the default field layout of a FIFO word {last, id, payload}.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 2;

  localparam int DATA_LSB = 0;
  localparam int ID_LSB   = DATA_LSB + DEF_DATA_WIDTH;
  localparam int LAST_BIT = ID_LSB + DEF_ID_WIDTH;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first requester at or after ptr
// (modulo NUM_REQ) whose request bit is set.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_valid
);

  logic [ID_WIDTH-1:0] idx_s;

  // Scan from the farthest offset back to ptr so the nearest hit is kept last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx_s     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_s = ptr + ID_WIDTH'(i);
      if (req[idx_s]) begin
        winner    = idx_s;
        any_valid = 1'b1;
      end else begin
        winner    = winner;
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one sync_fifo write port
// between NUM_REQ requesters; words are tagged {last, id, payload}.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_WIDTH  = 1 + ID_WIDTH + DATA_WIDTH,
  parameter int STALL_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [FIFO_WIDTH-1:0]         fifo_write_data,
  output logic                          locked,
  output logic [ID_WIDTH-1:0]           owner_id,
  output logic [STALL_CNT_W-1:0]        stall_cnt
);

  arb_state_e              state_r;
  logic [ID_WIDTH-1:0]     owner_r;
  logic [ID_WIDTH-1:0]     rr_ptr_r;
  logic [STALL_CNT_W-1:0]  stall_r;

  logic [ID_WIDTH-1:0]     winner_s;
  logic                    any_valid_s;
  logic [ID_WIDTH-1:0]     grant_s;
  logic                    grant_ok_s;
  logic [NUM_REQ-1:0]      ready_s;
  logic                    xfer_s;
  logic                    last_s;
  logic [DATA_WIDTH-1:0]   data_arr_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Grant selection: a locked owner keeps the port even while its valid is low.
  always_comb begin
    grant_s    = winner_s;
    grant_ok_s = any_valid_s;
    ready_s    = '0;
    if (state_r == ST_LOCKED) begin
      grant_s    = owner_r;
      grant_ok_s = 1'b1;
    end else begin
      grant_s    = winner_s;
      grant_ok_s = any_valid_s;
    end
    if (grant_ok_s && !fifo_full) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s          = |(req_valid & ready_s);
  assign last_s          = req_last[grant_s];
  assign req_ready       = ready_s;
  assign fifo_write_en   = xfer_s;
  assign fifo_write_data = {last_s, grant_s, data_arr_s[grant_s]};
  assign locked          = (state_r == ST_LOCKED);
  assign owner_id        = owner_r;
  assign stall_cnt       = stall_r;

  // Lock FSM: tracks packet ownership and advances the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            owner_r <= winner_s;
            if (last_s) begin
              rr_ptr_r <= winner_s + ID_WIDTH'(1);
            end else begin
              state_r <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (xfer_s && last_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= owner_r + ID_WIDTH'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of cycles where a requester is held off by a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= '0;
    end else if ((|req_valid) && fifo_full && (stall_r != {STALL_CNT_W{1'b1}})) begin
      stall_r <= stall_r + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by
// randomized packet traffic, all compared against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 32;
  localparam int FW = 1 + IW + DW;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_write_en;
  logic [FW-1:0]   fifo_write_data;
  logic            locked;
  logic [IW-1:0]   owner_id;
  logic [SW-1:0]   stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_stall;
  int locked_cycles;
  int left [N];
  int x;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IW), .DATA_WIDTH(DW), .FIFO_WIDTH(FW), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .locked(locked), .owner_id(owner_id), .stall_cnt(stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_stall  = 0;
  endtask

  // Requester allowed to write this cycle, or -1.
  function automatic int pick_grant();
    if (fifo_full) return -1;
    if (m_locked) return m_owner;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input bit l, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*DW +: DW] = d;
  endtask

  // One cycle: called just after a falling edge with inputs already driven.
  task automatic step(output int xfer_id);
    logic [N-1:0]  exp_ready;
    logic [FW-1:0] exp_word;
    logic [IW-1:0] gid;
    int g;
    bit wr;
    #1;
    g = pick_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    wr = (g >= 0) && req_valid[g];
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("write_en", fifo_write_en, wr);
    if (wr) begin
      gid = IW'(g);
      exp_word = {req_last[g], gid, req_data[g*DW +: DW]};
      check_eq("write_data", fifo_write_data, exp_word);
    end
    check_eq("locked", locked, m_locked);
    check_eq("owner_id", owner_id, m_owner);
    check_eq("stall_cnt", stall_cnt, m_stall);
    if (locked) locked_cycles++;
    xfer_id = wr ? g : -1;
    @(posedge clk);
    if ((|req_valid) && fifo_full && m_stall < SAT) m_stall++;
    if (wr) begin
      m_owner = g;
      if (req_last[g]) begin
        m_locked = 1'b0;
        m_ptr = (g + 1) % N;
      end else begin
        m_locked = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_locked", locked, 1'b0);
    check_eq("rst_owner", owner_id, 0);
    check_eq("rst_stall", stall_cnt, 0);
    check_eq("rst_wen", fifo_write_en, 1'b0);
    check_eq("rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin over single-beat packets
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 32'h100 + i);
    for (int k = 0; k < 5; k++) begin
      step(x);
      check_eq("rr_order", x, k % N);
    end

    // Requester 2 locks a 3-beat packet while requester 1 waits
    req_valid = '0;
    set_req(1, 1'b1, 1'b1, 32'h11);
    step(x);
    check_eq("pre_r1", x, 1);
    set_req(2, 1'b1, 1'b0, 32'hA0);
    locked_cycles = 0;
    step(x);
    check_eq("pkt_b0", x, 2);
    set_req(2, 1'b1, 1'b0, 32'hA1);
    step(x);
    check_eq("pkt_b1", x, 2);
    set_req(2, 1'b1, 1'b1, 32'hA2);
    step(x);
    check_eq("pkt_b2", x, 2);
    set_req(2, 1'b0, 1'b0, 32'h0);
    step(x);
    check_eq("after_pkt", x, 1);
    check_eq("locked_len", locked_cycles, 2);

    // Full FIFO holds off requester 0
    req_valid = '0;
    set_req(0, 1'b1, 1'b1, 32'hC0);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(x);
      check_eq("full_hold", x, -1);
    end
    check_eq("stall5", stall_cnt, 5);
    fifo_full = 1'b0;
    step(x);
    check_eq("full_release", x, 0);

    // Owner 3 pauses mid-packet; requester 0 must not sneak in
    set_req(0, 1'b1, 1'b1, 32'hD0);
    set_req(3, 1'b1, 1'b0, 32'h30);
    step(x);
    check_eq("own3_b0", x, 3);
    set_req(3, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(x);
      check_eq("own3_gap", x, -1);
      check_eq("own3_lock", locked, 1'b1);
    end
    set_req(3, 1'b1, 1'b1, 32'h31);
    step(x);
    check_eq("own3_b1", x, 3);
    set_req(3, 1'b0, 1'b0, 32'h0);
    step(x);
    check_eq("r0_after", x, 0);

    // Stall counter saturation
    req_valid = '0;
    set_req(0, 1'b1, 1'b1, 32'hE0);
    fifo_full = 1'b1;
    for (int k = 0; k < 20; k++) step(x);
    check_eq("stall_sat", stall_cnt, SAT);
    fifo_full = 1'b0;
    req_valid = '0;

    // Reset during the second beat of a locked packet
    set_req(1, 1'b1, 1'b0, 32'hB0);
    step(x);
    check_eq("rst_pkt_b0", x, 1);
    set_req(1, 1'b1, 1'b0, 32'hB1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_locked", locked, 1'b0);
    check_eq("arst_owner", owner_id, 0);
    check_eq("arst_stall", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 32'h200 + i);
    step(x);
    check_eq("post_rst_win", x, 0);

    // Randomized packet traffic
    req_valid = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          if (left[i] == 0) left[i] = $urandom_range(1, 4);
          set_req(i, 1'b1, left[i] == 1, $urandom);
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      step(x);
      if (x >= 0) begin
        left[x]--;
        req_valid[x] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
